// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t    receiver FSM states
//   DEFAULT_*     default clock and line-rate constants
//   clks_per_bit  system clocks per serial bit (integer truncation)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word handshake and error strobes.
//   rx_data      received word, stable while rx_valid
//   rx_valid     holding register has an unread word
//   rx_ready     consumer accepts on rx_valid && rx_ready
//   frame_err    one-cycle pulse, bad stop bit
//   overrun_err  one-cycle pulse, unread word overwritten
//   parity_err   one-cycle pulse, parity mismatch (only with UART_RX_PARITY_EN)
// master = receiver side, slave = consumer side.
interface uart_rx_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output rx_data, rx_valid, frame_err, overrun_err, parity_err,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun_err, parity_err,
                  output rx_ready);
`else
  modport master (output rx_data, rx_valid, frame_err, overrun_err,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun_err,
                  output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial pin plus falling-edge detect.
//   clk, reset   system clock, synchronous active-high reset
//   uart_rx      asynchronous serial pin (idle high)
//   rx_s         synchronized line value (reset to 1 = idle)
//   rx_fall_c    combinational: rx_s went 1->0 this cycle
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  output logic rx_s,
  output logic rx_fall_c
);

  logic       rx_meta;
  logic       rx_s_d;
  // Marks which stages hold a real pin sample rather than the reset preset,
  // so a line held low through reset is not mistaken for a start edge.
  logic [2:0] sampled;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
      sampled <= 3'b000;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      sampled <= {sampled[1:0], 1'b1};
    end
  end

  assign rx_fall_c = sampled[2] & rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: mid-bit sampling UART receiver (start + DATA_BITS [+ parity] + stop).
//   clk, reset  system clock, synchronous active-high reset
//   uart_rx     asynchronous serial line, idle high
//   busy        high whenever the receiver FSM is not IDLE
//   rx          uart_rx_core_if.master: rx_data/rx_valid/rx_ready handshake,
//               frame_err, overrun_err (and parity_err) pulses
// Optional feature macro: UART_RX_PARITY_EN adds PARITY_ODD, a PARITY state and parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD      = DEFAULT_BAUD,
  parameter int unsigned DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rx,
  output logic           busy,
  uart_rx_core_if.master rx
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 commit_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_err_q;

  logic                 rx_s;
  logic                 rx_fall_c;
  logic                 cnt_last_c;
  logic                 cnt_clr_c;
  logic                 shift_en_c;
  logic                 stop_smp_c;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_s      (rx_s),
    .rx_fall_c (rx_fall_c)
  );

  assign cnt_last_c = (clk_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (rx_fall_c) state_nxt = START;
      START:  if (clk_cnt == CNT_MID) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt_last_c && (bit_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (cnt_last_c) state_nxt = STOP;
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      STOP:   if (cnt_last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_smp_c;
  logic par_bad_q;
  logic parity_err_q;
`endif

  // Per-state control strobes.
  always_comb begin
    cnt_clr_c  = 1'b0;
    shift_en_c = 1'b0;
    stop_smp_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp_c  = 1'b0;
`endif
    case (state)
      IDLE:  cnt_clr_c = 1'b1;
      START: cnt_clr_c = (clk_cnt == CNT_MID);
      DATA: begin
        shift_en_c = cnt_last_c;
        cnt_clr_c  = cnt_last_c;
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        par_smp_c = cnt_last_c;
`endif
        cnt_clr_c = cnt_last_c;
      end
      STOP: begin
        stop_smp_c = cnt_last_c;
        cnt_clr_c  = cnt_last_c;
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  // Bit timing, shift register and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      commit_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy          <= 1'b0;
    end else begin
      clk_cnt <= cnt_clr_c ? '0 : clk_cnt + CNT_W'(1);

      if (state == START)  bit_idx <= '0;
      else if (shift_en_c) bit_idx <= bit_idx + IDX_W'(1);

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (shift_en_c) shift <= {rx_s, shift[DATA_BITS-1:1]};

      commit_q      <= stop_smp_c & rx_s;
      frame_err_q   <= stop_smp_c & ~rx_s;
      overrun_err_q <= commit_q & rx_valid_q & ~rx.rx_ready;

      if (commit_q) begin
        rx_data_q  <= shift;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      busy <= (state_nxt != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch is remembered until the commit cycle; a bad stop bit suppresses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (par_smp_c) par_bad_q <= rx_s ^ (^shift) ^ PARITY_ODD;
      parity_err_q <= commit_q & par_bad_q;
    end
  end

  assign rx.parity_err = parity_err_q;
`endif

  assign rx.rx_data     = rx_data_q;
  assign rx.rx_valid    = rx_valid_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.overrun_err = overrun_err_q;

endmodule
